// File: rtl/pdpm_axis_chan_switch.sv
// AXI-S switch between the network byte streams and NUM_CH memory channels.
// Statistics counters exist only when PDPM_SWITCH_STATS_EN is defined.
module pdpm_axis_chan_switch #(
  parameter int DATA_W = 8,
  parameter int NUM_CH = 2,
  parameter int CH_W   = 1,
  parameter int CNT_W  = 16
) (
  input  logic                     sys_clk,
  input  logic                     glbl_rst,

  input  logic [DATA_W-1:0]        s_net_tdata,
  input  logic                     s_net_tvalid,
  input  logic                     s_net_tlast,
  output logic                     s_net_tready,

  output logic [NUM_CH*DATA_W-1:0] m_ch_tdata,
  output logic [NUM_CH-1:0]        m_ch_tvalid,
  output logic [NUM_CH-1:0]        m_ch_tlast,
  input  logic [NUM_CH-1:0]        m_ch_tready,

  input  logic [NUM_CH*DATA_W-1:0] s_ch_tdata,
  input  logic [NUM_CH-1:0]        s_ch_tvalid,
  input  logic [NUM_CH-1:0]        s_ch_tlast,
  output logic [NUM_CH-1:0]        s_ch_tready,

  output logic [DATA_W-1:0]        m_net_tdata,
  output logic                     m_net_tvalid,
  output logic                     m_net_tlast,
  input  logic                     m_net_tready,

  output logic [CNT_W-1:0]         stat_rx_pkts,
  output logic [CNT_W-1:0]         stat_drop_pkts,
  output logic [CNT_W-1:0]         stat_tx_pkts
);

  generate
    if (CH_W != $clog2(NUM_CH)) begin : g_bad_ch_w
      $error("pdpm_axis_chan_switch: CH_W must equal clog2(NUM_CH)");
    end
    if (NUM_CH < 2 || NUM_CH > 8) begin : g_bad_num_ch
      $error("pdpm_axis_chan_switch: NUM_CH must be in 2..8");
    end
  endgenerate

  typedef enum logic [1:0] {IN_IDLE, IN_FWD, IN_DROP} in_state_t;
  typedef enum logic {EG_IDLE, EG_LOCK} eg_state_t;

  in_state_t       in_state, in_next;
  logic [CH_W-1:0] dest_q, dest_d;
  eg_state_t       eg_state, eg_next;
  logic [CH_W-1:0] grant_q, grant_d;
  logic [CH_W-1:0] ptr_q, ptr_d;
  logic            arb_found;
  logic [CH_W-1:0] arb_sel;
  logic            rx_done, drop_done, tx_done;

  always_ff @(posedge sys_clk or posedge glbl_rst) begin
    if (glbl_rst) begin
      in_state <= IN_IDLE;
      dest_q   <= '0;
      eg_state <= EG_IDLE;
      grant_q  <= '0;
      ptr_q    <= CH_W'(NUM_CH - 1);
    end else begin
      in_state <= in_next;
      dest_q   <= dest_d;
      eg_state <= eg_next;
      grant_q  <= grant_d;
      ptr_q    <= ptr_d;
    end
  end

  // Ingress: the header beat is only peeked in IDLE, then replayed through FWD.
  always_comb begin
    in_next      = in_state;
    dest_d       = dest_q;
    s_net_tready = 1'b0;
    m_ch_tvalid  = '0;
    m_ch_tlast   = '0;
    m_ch_tdata   = '0;
    rx_done      = 1'b0;
    drop_done    = 1'b0;
    case (in_state)
      IN_IDLE: begin
        if (s_net_tvalid) begin
          dest_d = s_net_tdata[CH_W-1:0];
          if (int'(s_net_tdata[CH_W-1:0]) < NUM_CH) in_next = IN_FWD;
          else                                      in_next = IN_DROP;
        end
      end
      IN_FWD: begin
        m_ch_tvalid[dest_q]                         = s_net_tvalid;
        m_ch_tlast[dest_q]                          = s_net_tlast;
        m_ch_tdata[int'(dest_q)*DATA_W +: DATA_W]   = s_net_tdata;
        s_net_tready                                = m_ch_tready[dest_q];
        if (s_net_tvalid && m_ch_tready[dest_q] && s_net_tlast) begin
          rx_done = 1'b1;
          in_next = IN_IDLE;
        end
      end
      IN_DROP: begin
        s_net_tready = 1'b1;
        if (s_net_tvalid && s_net_tlast) begin
          drop_done = 1'b1;
          in_next   = IN_IDLE;
        end
      end
      default: in_next = IN_IDLE;
    endcase
  end

  // Round-robin search starting one past the last channel that completed a packet.
  always_comb begin
    int idx;
    idx       = 0;
    arb_found = 1'b0;
    arb_sel   = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      idx = (int'(ptr_q) + i) % NUM_CH;
      if (!arb_found && s_ch_tvalid[idx[CH_W-1:0]]) begin
        arb_found = 1'b1;
        arb_sel   = idx[CH_W-1:0];
      end
    end
  end

  always_comb begin
    eg_next      = eg_state;
    grant_d      = grant_q;
    ptr_d        = ptr_q;
    s_ch_tready  = '0;
    m_net_tvalid = 1'b0;
    m_net_tlast  = 1'b0;
    m_net_tdata  = '0;
    tx_done      = 1'b0;
    case (eg_state)
      EG_IDLE: begin
        if (arb_found) begin
          grant_d = arb_sel;
          eg_next = EG_LOCK;
        end
      end
      EG_LOCK: begin
        m_net_tvalid         = s_ch_tvalid[grant_q];
        m_net_tlast          = s_ch_tlast[grant_q];
        m_net_tdata          = s_ch_tdata[int'(grant_q)*DATA_W +: DATA_W];
        s_ch_tready[grant_q] = m_net_tready;
        if (s_ch_tvalid[grant_q] && m_net_tready && s_ch_tlast[grant_q]) begin
          ptr_d   = grant_q;
          tx_done = 1'b1;
          eg_next = EG_IDLE;
        end
      end
      default: eg_next = EG_IDLE;
    endcase
  end

`ifdef PDPM_SWITCH_STATS_EN
  logic [CNT_W-1:0] rx_cnt, drop_cnt, tx_cnt;

  always_ff @(posedge sys_clk or posedge glbl_rst) begin
    if (glbl_rst) begin
      rx_cnt   <= '0;
      drop_cnt <= '0;
      tx_cnt   <= '0;
    end else begin
      if (rx_done && (rx_cnt != '1))     rx_cnt   <= rx_cnt + 1'b1;
      if (drop_done && (drop_cnt != '1)) drop_cnt <= drop_cnt + 1'b1;
      if (tx_done && (tx_cnt != '1))     tx_cnt   <= tx_cnt + 1'b1;
    end
  end

  assign stat_rx_pkts   = rx_cnt;
  assign stat_drop_pkts = drop_cnt;
  assign stat_tx_pkts   = tx_cnt;
`else
  logic stats_unused;
  assign stats_unused   = ^{rx_done, drop_done, tx_done};
  assign stat_rx_pkts   = '0;
  assign stat_drop_pkts = '0;
  assign stat_tx_pkts   = '0;
`endif

endmodule

// File: tb/tb_pdpm_axis_chan_switch.sv
// Bench for pdpm_axis_chan_switch: directed steps plus randomized traffic
// checked against queue-based ingress routing and round-robin egress models.
module tb_pdpm_axis_chan_switch;
  localparam int DW     = 8;
  localparam int NC     = 3;
  localparam int CW     = 2;
  localparam int CNTW   = 4;
  localparam int SATMAX = (1 << CNTW) - 1;

  logic              sys_clk = 1'b0;
  logic              glbl_rst;
  logic [DW-1:0]     s_net_tdata;
  logic              s_net_tvalid, s_net_tlast, s_net_tready;
  logic [NC*DW-1:0]  m_ch_tdata;
  logic [NC-1:0]     m_ch_tvalid, m_ch_tlast, m_ch_tready;
  logic [NC*DW-1:0]  s_ch_tdata;
  logic [NC-1:0]     s_ch_tvalid, s_ch_tlast, s_ch_tready;
  logic [DW-1:0]     m_net_tdata;
  logic              m_net_tvalid, m_net_tlast, m_net_tready;
  logic [CNTW-1:0]   stat_rx_pkts, stat_drop_pkts, stat_tx_pkts;

  pdpm_axis_chan_switch #(.DATA_W(DW), .NUM_CH(NC), .CH_W(CW), .CNT_W(CNTW)) dut (
    .sys_clk(sys_clk), .glbl_rst(glbl_rst),
    .s_net_tdata(s_net_tdata), .s_net_tvalid(s_net_tvalid), .s_net_tlast(s_net_tlast),
    .s_net_tready(s_net_tready),
    .m_ch_tdata(m_ch_tdata), .m_ch_tvalid(m_ch_tvalid), .m_ch_tlast(m_ch_tlast),
    .m_ch_tready(m_ch_tready),
    .s_ch_tdata(s_ch_tdata), .s_ch_tvalid(s_ch_tvalid), .s_ch_tlast(s_ch_tlast),
    .s_ch_tready(s_ch_tready),
    .m_net_tdata(m_net_tdata), .m_net_tvalid(m_net_tvalid), .m_net_tlast(m_net_tlast),
    .m_net_tready(m_net_tready),
    .stat_rx_pkts(stat_rx_pkts), .stat_drop_pkts(stat_drop_pkts), .stat_tx_pkts(stat_tx_pkts)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct packed {logic [7:0] d; logic l; logic f;} beat_t;

  beat_t net_src[$];
  beat_t exp_ch[NC][$];
  beat_t ch_src[NC][$];
  beat_t exp_eg[NC][$];
  int    act_order[$];

  int vectors = 0, miscompares = 0;
  int rx_tot = 0, drop_tot = 0, tx_tot = 0;
  int m_ptr = NC - 1, m_cur = -1, seq = 0;
  int rdy_mode = 0;
  bit gaps = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int n);
    int lim;
    lim = SATMAX;
`ifndef PDPM_SWITCH_STATS_EN
    lim = 0;
`endif
    return (n > lim) ? lim : n;
  endfunction

  function automatic bit drained();
    bit e;
    e = (net_src.size() == 0);
    for (int c = 0; c < NC; c++)
      e = e && exp_ch[c].size() == 0 && ch_src[c].size() == 0 && exp_eg[c].size() == 0;
    return e;
  endfunction

  task automatic push_net(input logic [7:0] d, input bit l, input bit f, input int dest);
    beat_t b;
    b = '{d: d, l: l, f: f};
    net_src.push_back(b);
    if (dest < NC) exp_ch[dest].push_back(b);
  endtask

  task automatic add_net_pkt(input logic [7:0] hdr, input int len);
    int dest;
    dest = int'(hdr[CW-1:0]);
    for (int k = 0; k < len; k++)
      push_net((k == 0) ? hdr : 8'($urandom), k == len - 1, k == 0, dest);
    if (dest < NC) rx_tot++;
    else           drop_tot++;
  endtask

  task automatic add_eg_pkt(input int c, input int len);
    beat_t b;
    for (int k = 0; k < len; k++) begin
      b = '{d: {c[1:0], seq[5:0]}, l: k == len - 1, f: k == 0};
      seq++;
      ch_src[c].push_back(b);
      exp_eg[c].push_back(b);
    end
  endtask

  task automatic model_reset();
    net_src.delete();
    for (int c = 0; c < NC; c++) begin
      exp_ch[c].delete(); ch_src[c].delete(); exp_eg[c].delete();
    end
    m_ptr = NC - 1; m_cur = -1;
    rx_tot = 0; drop_tot = 0; tx_tot = 0;
  endtask

  // One clock: drive at the falling edge, check settled outputs 1 time unit later.
  task automatic step();
    int  pick;
    @(negedge sys_clk);
    if (net_src.size() > 0 && (!gaps || $urandom_range(3) != 0)) begin
      s_net_tvalid = 1'b1; s_net_tdata = net_src[0].d; s_net_tlast = net_src[0].l;
    end else begin
      s_net_tvalid = 1'b0; s_net_tdata = '0; s_net_tlast = 1'b0;
    end
    for (int c = 0; c < NC; c++) begin
      if (ch_src[c].size() > 0 && (ch_src[c][0].f || !gaps || $urandom_range(3) != 0)) begin
        s_ch_tvalid[c] = 1'b1; s_ch_tdata[c*DW +: DW] = ch_src[c][0].d; s_ch_tlast[c] = ch_src[c][0].l;
      end else begin
        s_ch_tvalid[c] = 1'b0; s_ch_tdata[c*DW +: DW] = '0; s_ch_tlast[c] = 1'b0;
      end
    end
    case (rdy_mode)
      0: begin m_ch_tready = '1; m_net_tready = 1'b1; end
      1: begin
        for (int c = 0; c < NC; c++) m_ch_tready[c] = 1'($urandom_range(1));
        m_net_tready = 1'($urandom_range(1));
      end
      default: begin m_ch_tready = {{(NC-1){1'b1}}, ~m_ch_tready[0]}; m_net_tready = 1'b1; end
    endcase
    #1;
    // ingress: routed beats must come out of that channel's queue in order
    chk("in_onehot", 32'($countones(m_ch_tvalid) <= 1), 1);
    for (int c = 0; c < NC; c++) begin
      if (m_ch_tvalid[c] === 1'b1) begin
        chk("in_ready_mirror", s_net_tready, m_ch_tready[c]);
        if (m_ch_tready[c]) begin
          chk("in_beat_expected", 32'(exp_ch[c].size() > 0), 1);
          if (exp_ch[c].size() > 0) begin
            chk("in_tdata", m_ch_tdata[c*DW +: DW], exp_ch[c][0].d);
            chk("in_tlast", m_ch_tlast[c], exp_ch[c][0].l);
            void'(exp_ch[c].pop_front());
          end
        end
      end
    end
    if (s_net_tvalid && s_net_tready === 1'b1) void'(net_src.pop_front());
    // egress: packet-atomic round robin over channels holding packets
    chk("eg_onehot", 32'($countones(s_ch_tready) <= 1), 1);
    if (m_net_tvalid === 1'b1 && m_net_tready) begin
      chk("eg_ready_one", 32'($countones(s_ch_tready & s_ch_tvalid)), 1);
      if (m_cur < 0) begin
        pick = -1;
        for (int i = 1; i <= NC; i++)
          if (pick < 0 && exp_eg[(m_ptr + i) % NC].size() > 0) pick = (m_ptr + i) % NC;
        chk("eg_grant_expected", 32'(pick >= 0), 1);
        m_cur = pick;
        act_order.push_back(int'(m_net_tdata[7:6]));
      end
      if (m_cur >= 0) begin
        chk("eg_tdata", m_net_tdata, exp_eg[m_cur][0].d);
        chk("eg_tlast", m_net_tlast, exp_eg[m_cur][0].l);
        if (exp_eg[m_cur][0].l) begin
          void'(exp_eg[m_cur].pop_front());
          m_ptr = m_cur; m_cur = -1; tx_tot++;
        end else begin
          void'(exp_eg[m_cur].pop_front());
        end
      end
    end
    for (int c = 0; c < NC; c++)
      if (s_ch_tvalid[c] && s_ch_tready[c] === 1'b1) void'(ch_src[c].pop_front());
  endtask

  task automatic run(input int budget, input string tag);
    for (int n = 0; n < budget && !drained(); n++) step();
    chk({tag, "_drain_timeout"}, 32'(drained()), 1);
    step();
    step();
    chk({tag, "_stat_rx"},   stat_rx_pkts,   sat(rx_tot));
    chk({tag, "_stat_drop"}, stat_drop_pkts, sat(drop_tot));
    chk({tag, "_stat_tx"},   stat_tx_pkts,   sat(tx_tot));
  endtask

  initial begin
    logic [7:0] h;
    glbl_rst = 1'b1;
    s_net_tvalid = 1'b0; s_net_tdata = '0; s_net_tlast = 1'b0;
    s_ch_tvalid = '0; s_ch_tdata = '0; s_ch_tlast = '0;
    m_ch_tready = '1; m_net_tready = 1'b1;
    @(negedge sys_clk);
    @(negedge sys_clk);
    #1;
    chk("rst_s_net_tready", s_net_tready, 0);
    chk("rst_m_ch_tvalid",  m_ch_tvalid,  0);
    chk("rst_m_ch_tdata",   m_ch_tdata,   0);
    chk("rst_m_ch_tlast",   m_ch_tlast,   0);
    chk("rst_s_ch_tready",  s_ch_tready,  0);
    chk("rst_m_net_tvalid", m_net_tvalid, 0);
    chk("rst_m_net_tdata",  m_net_tdata,  0);
    chk("rst_m_net_tlast",  m_net_tlast,  0);
    chk("rst_stat_rx",      stat_rx_pkts, 0);
    glbl_rst = 1'b0;

    // ingress to channel 1 with one bubble cycle
    push_net(8'h01, 1'b0, 1'b1, 1);
    push_net(8'hAA, 1'b0, 1'b0, 1);
    push_net(8'hBB, 1'b1, 1'b0, 1);
    rx_tot++;
    step();
    chk("t1_bubble_ready", s_net_tready, 0);
    chk("t1_bubble_valid", m_ch_tvalid, 0);
    run(50, "t1");

    // out-of-range header is dropped, then channel 2 is routed
    add_net_pkt(8'h03, 4);
    add_net_pkt(8'h02, 3);
    run(50, "t2");

    // egress round robin between channels 0 and 1
    act_order.delete();
    add_eg_pkt(0, 2); add_eg_pkt(0, 2);
    add_eg_pkt(1, 2); add_eg_pkt(1, 2);
    run(60, "t3");
    chk("t3_npkts", act_order.size(), 4);
    for (int i = 0; i < act_order.size() && i < 4; i++) chk("t3_order", act_order[i], i % 2);

    // toggling backpressure on channel 0
    rdy_mode = 2;
    add_net_pkt(8'h00, 5);
    run(60, "t4");

    // randomized concurrent ingress and egress
    rdy_mode = 1; gaps = 1'b1;
    for (int i = 0; i < 40; i++) begin
      h = 8'($urandom);
      add_net_pkt(h, $urandom_range(1, 5));
      add_eg_pkt($urandom_range(0, NC - 1), $urandom_range(1, 4));
    end
    run(4000, "rand");

    // reset in the middle of an egress packet, after channel 0 was last served
    rdy_mode = 0; gaps = 1'b0;
    add_eg_pkt(0, 1);
    run(30, "t5a");
    add_eg_pkt(2, 4);
    for (int n = 0; n < 30 && ch_src[2].size() > 2; n++) step();
    chk("t5_mid_packet", ch_src[2].size(), 2);
    @(negedge sys_clk);
    glbl_rst = 1'b1;
    #1;
    chk("t5_rst_m_net_tvalid", m_net_tvalid, 0);
    chk("t5_rst_s_ch_tready",  s_ch_tready,  0);
    chk("t5_rst_m_ch_tvalid",  m_ch_tvalid,  0);
    chk("t5_rst_s_net_tready", s_net_tready, 0);
    model_reset();
    s_ch_tvalid = '0; s_ch_tdata = '0; s_ch_tlast = '0;
    @(negedge sys_clk);
    glbl_rst = 1'b0;
    act_order.delete();
    add_eg_pkt(0, 1);
    add_eg_pkt(2, 1);
    run(30, "t5b");
    chk("t5_npkts", act_order.size(), 2);
    if (act_order.size() > 0) chk("t5_first_grant", act_order[0], 0);

    // counter saturation with single-beat packets
    for (int i = 0; i < 20; i++) add_net_pkt((i % 3 == 0) ? 8'h01 : 8'h00, 1);
    run(200, "t6");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
